// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared constants for the iterative magnitude comparator:
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - result encoding (LT / EQ / GT)
//   - num_chunks(): number of CHUNK-bit slices in a WIDTH-bit operand
// No ports (package).
// -----------------------------------------------------------------------------
package cmp_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Result encoding
    localparam logic [1:0] RES_LT = 2'd0;
    localparam logic [1:0] RES_EQ = 2'd1;
    localparam logic [1:0] RES_GT = 2'd2;

    // Number of CHUNK-bit slices in a WIDTH-bit operand
    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage : cmp_pkg

// File: rtl/iter_magnitude_comparator_chunk_compare.sv
// -----------------------------------------------------------------------------
// chunk_compare
// Combinational unsigned compare of two CHUNK-bit slices.
// Ports:
//   a_i, b_i  in  [CHUNK-1:0]  slices to compare
//   lt_o      out              a_i <  b_i
//   eq_o      out              a_i == b_i
//   gt_o      out              a_i >  b_i
// -----------------------------------------------------------------------------
module chunk_compare
    import cmp_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    assign lt_o = (a_i <  b_i);
    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);

endmodule : chunk_compare

// File: rtl/iter_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// iter_magnitude_comparator
// Multi-cycle magnitude comparator. Captures two WIDTH-bit operands on a
// valid/ready handshake and compares them CHUNK bits per cycle, most
// significant chunk first. Signed requests are turned into an unsigned compare
// by flipping both sign bits at capture (offset binary).
//
// Optional feature (macro CMP_EARLY_EXIT_EN):
//   defined   : leave BUSY as soon as a differing chunk is found
//   undefined : always scan every chunk; fixed latency NUM_CHUNKS+1
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   in_valid/in_ready  request handshake; in_ready high only in IDLE
//   a, b, is_signed    operands and signedness of the compare
//   out_valid/out_ready result handshake; result held until accepted
//   a_less_b, a_equal_b, a_greater_b  one-hot result, all 0 when !out_valid
//   busy               high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module iter_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_less_b,
    output logic             a_equal_b,
    output logic             a_greater_b,
    output logic             busy
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = ONE_W << (WIDTH - 1);

    // Operands must split into whole chunks
    if ((WIDTH % CHUNK) != 0) begin : g_cfg_err
        $error("iter_magnitude_comparator: WIDTH must be a multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       res_q, res_d;
`ifndef CMP_EARLY_EXIT_EN
    logic             seen_q, seen_d;
`endif

    logic             chunk_lt_s;
    logic             chunk_eq_s;
    logic             chunk_gt_s;
    logic [1:0]       chunk_res_s;

    // The captured operands are shifted left one chunk per BUSY cycle, so the
    // chunk under test is always the top CHUNK bits of the registers.
    chunk_compare #(
        .CHUNK (CHUNK)
    ) u_chunk_compare (
        .a_i  (a_q[WIDTH-1 -: CHUNK]),
        .b_i  (b_q[WIDTH-1 -: CHUNK]),
        .lt_o (chunk_lt_s),
        .eq_o (chunk_eq_s),
        .gt_o (chunk_gt_s)
    );

    // Encode the current chunk's comparison as a result code
    always_comb begin
        if (chunk_lt_s) begin
            chunk_res_s = RES_LT;
        end else if (chunk_gt_s) begin
            chunk_res_s = RES_GT;
        end else begin
            chunk_res_s = RES_EQ;
        end
    end

    // FSM next-state and datapath next-value logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        res_d   = res_q;
`ifndef CMP_EARLY_EXIT_EN
        seen_d  = seen_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Flipping both sign bits maps two's complement onto an
                    // order-preserving unsigned range.
                    a_d     = is_signed ? (a ^ MSB_MASK) : a;
                    b_d     = is_signed ? (b ^ MSB_MASK) : b;
                    idx_d   = '0;
                    res_d   = RES_EQ;
`ifndef CMP_EARLY_EXIT_EN
                    seen_d  = 1'b0;
`endif
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                a_d   = a_q << CHUNK;
                b_d   = b_q << CHUNK;
                idx_d = idx_q + IDX_ONE;
`ifdef CMP_EARLY_EXIT_EN
                if (!chunk_eq_s) begin
                    res_d   = chunk_res_s;
                    state_d = ST_DONE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
`else
                // Only the most significant differing chunk decides
                if (!seen_q && !chunk_eq_s) begin
                    res_d  = chunk_res_s;
                    seen_d = 1'b1;
                end else begin
                    seen_d = seen_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= RES_EQ;
`ifndef CMP_EARLY_EXIT_EN
            seen_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
`ifndef CMP_EARLY_EXIT_EN
            seen_q  <= seen_d;
`endif
        end
    end

    // Outputs decode straight from registers; flags are gated by DONE so they
    // are one-hot while out_valid and all zero otherwise.
    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign a_less_b    = out_valid && (res_q == RES_LT);
    assign a_equal_b   = out_valid && (res_q == RES_EQ);
    assign a_greater_b = out_valid && (res_q == RES_GT);

endmodule : iter_magnitude_comparator

// File: tb/tb_iter_magnitude_comparator.sv
module tb_iter_magnitude_comparator;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          is_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          a_less_b;
    logic          a_equal_b;
    logic          a_greater_b;
    logic          busy;

    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    bit            chk_en   = 1'b0;
    logic [2:0]    exp_flags = 3'b000;   // {lt, eq, gt}

    always #5 clk = ~clk;

    iter_magnitude_comparator #(.WIDTH(W), .CHUNK(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a_less_b    (a_less_b),
        .a_equal_b   (a_equal_b),
        .a_greater_b (a_greater_b),
        .busy        (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer compare; latency from the first differing chunk
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic ms, output logic [2:0] flags, output int lat);
        int ai;
        int bi;
        int x;
        bit found;
        if (ms) begin
            ai = int'($signed(ma));
            bi = int'($signed(mb));
        end else begin
            ai = int'(ma);
            bi = int'(mb);
        end
        flags = (ai < bi) ? 3'b100 : ((ai == bi) ? 3'b010 : 3'b001);
        lat = N + 1;
        x = int'(ma ^ mb);
        found = 1'b0;
`ifdef CMP_EARLY_EXIT_EN
        for (int i = 0; i < N; i++) begin
            if (!found && (((x >> ((N - 1 - i) * C)) & 15) != 0)) begin
                lat = i + 2;
                found = 1'b1;
            end
        end
`else
        if (x != 0) found = 1'b1;
`endif
    endfunction

    // Per-cycle output check against the model's expectation
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (out_valid) begin
                check("flags", int'({a_less_b, a_equal_b, a_greater_b}), int'(exp_flags));
            end else begin
                check("flags_idle", int'({a_less_b, a_equal_b, a_greater_b}), 0);
            end
            check("busy_vs_ready", int'(busy), int'(!in_ready));
        end
    end

    task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts,
                         input bit hold, input logic [W-1:0] na, input logic [W-1:0] nb,
                         output int lat);
        int w;
        logic [2:0] f;
        w = 0;
        @(negedge clk);
        check("out_valid_low", int'(out_valid), 0);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", int'(in_ready), 1);
        a = ta; b = tb2; is_signed = ts; in_valid = 1'b1;
        model(ta, tb2, ts, f, lat);
        exp_flags = f;
        @(posedge clk);
        #1;
        if (hold) begin
            a = na; b = nb; is_signed = ~ts;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic finish(input int lat, input int hold, input string tag);
        int c;
        c = 1;
        @(negedge clk);
        while (!out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_latency"}, c, lat);
        repeat (hold) @(negedge clk);
        check({tag, "_held"}, int'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f;
        int lat;
        int lat2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] flip;
        logic rs;

        // Pin the model with hand-computed values
        model(16'h8000, 16'h7FFF, 1'b0, f, lat);
        check("pin_u_gt", int'(f), 1);
`ifdef CMP_EARLY_EXIT_EN
        check("pin_lat_early", lat, 2);
`else
        check("pin_lat_full", lat, 5);
`endif
        model(16'h8000, 16'h7FFF, 1'b1, f, lat);
        check("pin_s_lt", int'(f), 4);
        model(16'h1234, 16'h1234, 1'b0, f, lat);
        check("pin_eq", int'(f), 2);
        check("pin_eq_lat", lat, 5);
        model(16'h1235, 16'h1234, 1'b0, f, lat);
        check("pin_late_gt", int'(f), 1);
        check("pin_late_lat", lat, 5);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_flags", int'({a_less_b, a_equal_b, a_greater_b}), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", int'(in_ready), 1);
        check("rel_busy", int'(busy), 0);
        chk_en = 1'b1;

        // MSB difference, unsigned then signed
        start(16'h8000, 16'h7FFF, 1'b0, 1'b0, '0, '0, lat);
        finish(lat, 0, "u_8000");
        start(16'h8000, 16'h7FFF, 1'b1, 1'b0, '0, '0, lat);
        finish(lat, 1, "s_8000");

        // Equal operands, result held 3 cycles under backpressure
        start(16'h1234, 16'h1234, 1'b0, 1'b0, '0, '0, lat);
        check("eq_lat_lit", lat, 5);
        finish(lat, 3, "eq");

        // Difference in the last chunk only
        start(16'h1235, 16'h1234, 1'b0, 1'b0, '0, '0, lat);
        finish(5, 0, "late");

        // Request held high while busy with new operands
        start(16'h00F0, 16'h0F00, 1'b0, 1'b1, 16'hFFFF, 16'h8000, lat);
        finish(lat, 2, "bp_first");
        start(16'hFFFF, 16'h8000, 1'b1, 1'b0, '0, '0, lat2);
        check("bp_second_exp", int'(exp_flags), 1);
        finish(lat2, 0, "bp_second");

        // Reset in cycle 2 of an operation
        start(16'h5555, 16'h5555, 1'b0, 1'b0, '0, '0, lat);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_out_valid", int'(out_valid), 0);
            check("midrst_busy", int'(busy), 0);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("postrst_no_result", int'(out_valid), 0);
        end
        start(16'h0001, 16'hFFFF, 1'b1, 1'b0, '0, '0, lat);
        finish(lat, 0, "postrst");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: rb = W'($urandom);
                1: rb = ra;
                default: begin
                    flip = W'($urandom_range(1, 15));
                    rb = ra ^ (flip << (C * $urandom_range(0, N - 1)));
                end
            endcase
            start(ra, rb, rs, 1'b0, '0, '0, lat);
            finish(lat, int'($urandom_range(0, 2)), "rand");
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_iter_magnitude_comparator
